// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding and slice width used by the top and its bench.
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;
    localparam int SLICE_SH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder4bit.sv
// 4-bit ripple slice: {co, s} = x + y + ci.
// Single slice datapath shared by every nibble of an operation.
module adder4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one 4-bit slice per cycle, LSB first.
// Result and carry-out are presented behind a valid/ready handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    generate
        if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cout;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic             w_ci;
    logic [3:0]       w_s;
    logic             w_co;

    assign w_a_sh = r_a >> {r_idx, {SLICE_SH{1'b0}}};
    assign w_b_sh = r_b >> {r_idx, {SLICE_SH{1'b0}}};
    assign cout   = r_cout;

    adder4bit u_slice (
        .x  (w_x),
        .y  (w_y),
        .ci (w_ci),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (r_idx == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Slice inputs are forced to zero outside RUN; sum is exposed only in DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sum       = '0;
        w_x       = 4'd0;
        w_y       = 4'd0;
        w_ci      = 1'b0;
        unique case (r_state)
            IDLE: in_ready = rst_n;
            RUN: begin
                busy = 1'b1;
                w_x  = w_a_sh[3:0];
                w_y  = w_b_sh[3:0];
                w_ci = r_carry;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                sum       = r_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IW'(i)) r_acc[i*SLICE_W +: SLICE_W] <= w_s;
                    end
                    r_carry <= w_co;
                    if (r_idx == LAST) r_cout <= w_co;
                    else               r_idx  <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed bench for nibble_serial_adder.
// Reference results come from plain integer addition.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        v4, rdy4, c4, ov4, or4, co4, busy4;
    logic [3:0]  a4, b4, s4;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(rdy4),
        .a(a4), .b(b4), .cin(c4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .busy(busy4)
    );

    task automatic do_op(input logic [15:0] pa, input logic [15:0] pb,
                         input logic pc, input int hold, input string tag);
        logic [16:0] exp;
        int          edges;
        exp = {1'b0, pa} + {1'b0, pb} + {16'd0, pc};
        @(negedge clk);
        a = pa; b = pb; cin = pc; in_valid = 1'b1; out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: in_ready=%b want 1", tag, in_ready);
        end
        @(negedge clk);
        edges = 1;
        while (out_valid !== 1'b1 && edges < 20) begin
            n_checks++;
            if (busy !== 1'b1 || sum !== 16'h0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run: busy=%b sum=%h in_ready=%b want 1/0000/0",
                         tag, busy, sum, in_ready);
            end
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != 5) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges want 5", tag, edges);
        end
        for (int i = 0; i <= hold; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1
                || {cout, sum} !== exp) begin
                n_fail++;
                $display("FAIL %s result: ov=%b rdy=%b busy=%b {cout,sum}=%h want 1/0/1/%h",
                         tag, out_valid, in_ready, busy, {cout, sum}, exp);
            end
            if (i < hold) begin
                a = 16'h0F0F; in_valid = 1'b1;
                @(negedge clk);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain: ov=%b rdy=%b busy=%b want 0/1/0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        v4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; c4 = 1'b0;
        #3;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy/ov/busy/cout/sum=%h want 00000",
                     {in_ready, out_valid, busy, cout, sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || rdy4 !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b rdy4=%b busy=%b want 1/1/0",
                     in_ready, rdy4, busy);
        end
    endtask

    task automatic test_directed();
        do_op(16'h1234, 16'h4321, 1'b0, 0, "d_5555");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, "d_ripple");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "d_allones");
    endtask

    task automatic test_back_pressure();
        do_op(16'h1234, 16'h4321, 1'b0, 3, "bp_hold");
        do_op(16'h0F0F, 16'h00F1, 1'b0, 0, "bp_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, cout, in_ready, sum} !== 20'h0) begin
            n_fail++;
            $display("FAIL async_reset: ov/busy/cout/rdy/sum=%h want 00000",
                     {out_valid, busy, cout, in_ready, sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release: rdy=%b busy=%b want 1/0", in_ready, busy);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 0, "after_reset");
    endtask

    task automatic test_w4_exhaustive();
        logic [4:0] exp4;
        int         wait_n;
        or4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            a4 = i[3:0]; b4 = i[7:4]; c4 = i[8]; v4 = 1'b1;
            exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
            n_checks++;
            if (rdy4 !== 1'b1) begin
                n_fail++;
                $display("FAIL w4_ready[%0d]: rdy=%b want 1", i, rdy4);
            end
            @(negedge clk);
            v4 = 1'b0;
            wait_n = 0;
            while (ov4 !== 1'b1 && wait_n < 10) begin
                @(negedge clk);
                wait_n++;
            end
            n_checks++;
            if ({co4, s4} !== exp4 || wait_n != 1) begin
                n_fail++;
                $display("FAIL w4_sum[%0d]: {cout,sum}=%h wait=%0d want %h wait=1",
                         i, {co4, s4}, wait_n, exp4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_random();
        test_async_reset();
        test_w4_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder built around the existing adder4bit. It registers two operands and a carry-in, then feeds one 4-bit slice per cycle into adder4bit, least-significant slice first, with the carry held in a register between slices. It captures each 4-bit sum, then presents the full-width result and carry-out behind a valid/ready handshake. It sits directly upstream of adder4bit and drives its x, y and ci; it also consumes adder4bit's s and co.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration fails.
NIBBLES, WIDTH/4, derived (localparam), number of slices per operation.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a, b, cin valid this cycle.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry into slice 0.
out_valid  output  1  sum/cout valid; held until accepted.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered result, (a + b + cin) mod 2^WIDTH.
cout  output  1  registered carry out of the top slice.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, slice index=0, carry reg=0, operand regs=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=0 while rst_n low; in_ready=1 in the first cycle after release.
- State machine, IDLE / RUN / DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge: latch a, b; carry<=cin; idx<=0; sum reg<=0; go to RUN.
  - RUN: combinationally drive adder4bit x=a_reg[4*idx+:4], y=b_reg[4*idx+:4], ci=carry. Each edge: sum_reg[4*idx+:4]<=s; carry<=co; idx<=idx+1. When idx==NIBBLES-1: cout<=co, go to DONE.
  - DONE: out_valid=1. sum and cout are stable and do not change until the handshake. On out_valid&&out_ready: go to IDLE, out_valid deasserts next cycle.
- Latency: out_valid rises exactly NIBBLES+1 rising edges after the accept edge, i.e. NIBBLES RUN cycles. For WIDTH=4: one RUN cycle.
- Throughput: one operation per NIBBLES+2 cycles minimum. There is no accept in the same cycle as the output handshake; in_ready stays 0 in DONE.
- a, b, cin and in_valid are ignored outside IDLE. Changing them mid-operation must not affect the result.
- out_ready is ignored outside DONE.
- sum is visible at the port only as its final value: sum port=0 during RUN, and the full value once DONE is reached. Hold an internal accumulator and copy it on entry to DONE, or gate the output.
- idx counter width is max(1,$clog2(NIBBLES)). It never wraps in normal operation; its terminal value is NIBBLES-1.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values; a pending result is discarded.
- adder4bit inputs are driven to 0 outside RUN.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a SLICE_W=4 constant.
- One sub-module: the existing adder4bit, instantiated once as the slice datapath. No other sub-modules.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> sum=16'h5555, cout=0; out_valid rises 5 edges after the accept edge; busy high for the whole span.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Carry propagates through all 4 slices.
- a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Backpressure: after result 16'h5555, hold out_ready=0 for 3 cycles while driving in_valid=1 with a=16'h0F0F. Required: sum stays 16'h5555, in_ready=0, new operands ignored. After out_ready=1: IDLE, then the new operation is accepted.
- Drop rst_n asynchronously (mid-cycle) after 2 RUN cycles of 16'hAAAA+16'h5555 -> out_valid, sum, cout, busy all 0 immediately. After release: in_ready=1, and the next op 16'h0001+16'h0001 gives 16'h0002.
- WIDTH=4 instance, exhaustive over all 512 (x,y,ci) combinations from a vector file -> {cout,sum}==x+y+ci on every one; 0 errors reported.
